// File: rtl/pipe_seg_reg.sv
// Inter-stage pipeline segment register: CHANNELS x WIDTH payload plus valid,
// with bubble hold, flush kill, optional deferred flush and saturating event counters.
module pipe_seg_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      CHANNELS    = 2,
    parameter logic [WIDTH-1:0] FLUSH_VAL   = '0,
    parameter bit               DEFER_FLUSH = 1'b0,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bubble,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      flush_pending,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt,
    input  logic                      clr_cnt
);

    localparam int unsigned       DATA_W  = CHANNELS * WIDTH;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] flush_word;
    logic              apply_flush_c;
    logic              arm_flush_c;

    assign flush_word    = {CHANNELS{FLUSH_VAL}};
    // A held flush and a fresh flush on the same unbubbled edge are one event.
    assign apply_flush_c = !bubble && (flush || flush_pending);
    assign arm_flush_c   = DEFER_FLUSH && bubble && flush;

    // Payload, valid and deferred-flush flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= flush_word;
            out_valid     <= 1'b0;
            flush_pending <= 1'b0;
        end else if (bubble) begin
            if (arm_flush_c) begin
                flush_pending <= 1'b1;
            end
        end else if (apply_flush_c) begin
            out_data      <= flush_word;
            out_valid     <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            out_data  <= in_data;
            out_valid <= in_valid;
        end
    end

    // Saturating performance counters; clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bubble && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (apply_flush_c && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Bench for pipe_seg_reg: a default instance (immediate flush, 16-bit counters) and a
// NOP-flush / deferred-flush / 4-bit-counter instance driven from shared inputs.
module tb_pipe_seg_reg;

    typedef struct {
        logic        va;
        logic [63:0] da;
        logic        pa;
        logic [15:0] sa;
        logic [15:0] fa;
        logic        vb;
        logic [63:0] db;
        logic        pb;
        logic [3:0]  sb;
        logic [3:0]  fb;
    } exp_t;

    typedef struct {
        logic        bub;
        logic        fl;
        logic        clr;
        logic        iv;
        logic [63:0] d;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bubble, flush, in_valid, clr_cnt;
    logic [63:0] in_data;

    logic        va_o, pa_o, vb_o, pb_o;
    logic [63:0] da_o, db_o;
    logic [15:0] sa_o, fa_o;
    logic [3:0]  sb_o, fb_o;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    localparam logic [63:0] ZERO = 64'h0;
    localparam logic [63:0] NOPS = {2{32'h13}};

    always #5 clk = ~clk;

    pipe_seg_reg #(
        .WIDTH(32), .CHANNELS(2), .FLUSH_VAL(32'h0), .DEFER_FLUSH(1'b0), .CNT_W(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(va_o), .out_data(da_o), .flush_pending(pa_o),
        .stall_cnt(sa_o), .flush_cnt(fa_o), .clr_cnt(clr_cnt)
    );

    pipe_seg_reg #(
        .WIDTH(32), .CHANNELS(2), .FLUSH_VAL(32'h13), .DEFER_FLUSH(1'b1), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(vb_o), .out_data(db_o), .flush_pending(pb_o),
        .stall_cnt(sb_o), .flush_cnt(fb_o), .clr_cnt(clr_cnt)
    );

    function automatic logic [63:0] dd(input logic [31:0] hi, input logic [31:0] lo);
        return {hi, lo};
    endfunction

    function automatic exp_t mk_exp(
        input logic va, input logic [63:0] da, input logic [15:0] sa, input logic [15:0] fa,
        input logic vb, input logic [63:0] db, input logic pb, input logic [3:0] sb,
        input logic [3:0] fb);
        exp_t e;
        e.va = va; e.da = da; e.pa = 1'b0; e.sa = sa; e.fa = fa;
        e.vb = vb; e.db = db; e.pb = pb; e.sb = sb; e.fb = fb;
        return e;
    endfunction

    function automatic vec_t mk_vec(
        input logic bub, input logic fl, input logic clr, input logic iv,
        input logic [63:0] d, input exp_t e);
        vec_t v;
        v.bub = bub; v.fl = fl; v.clr = clr; v.iv = iv; v.d = d; v.e = e;
        return v;
    endfunction

    task automatic chk(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", tag, name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk(tag, "a_valid", 64'(va_o), 64'(e.va));
        chk(tag, "a_data",  da_o,      e.da);
        chk(tag, "a_pend",  64'(pa_o), 64'(e.pa));
        chk(tag, "a_stall", 64'(sa_o), 64'(e.sa));
        chk(tag, "a_flush", 64'(fa_o), 64'(e.fa));
        chk(tag, "b_valid", 64'(vb_o), 64'(e.vb));
        chk(tag, "b_data",  db_o,      e.db);
        chk(tag, "b_pend",  64'(pb_o), 64'(e.pb));
        chk(tag, "b_stall", 64'(sb_o), 64'(e.sb));
        chk(tag, "b_flush", 64'(fb_o), 64'(e.fb));
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string tag, input logic bub, input logic fl, input logic clr,
                        input logic iv, input logic [63:0] d, input exp_t e);
        exp_t got;
        bubble = bub; flush = fl; clr_cnt = clr; in_valid = iv; in_data = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.queue: got empty, expected one entry", tag);
        end else begin
            got = exp_q.pop_front();
            check_all(tag, got);
        end
    endtask

    initial begin
        vec_t        tbl[16];
        logic [63:0] last_d;
        logic        last_v;
        logic [63:0] d;
        logic        iv;

        tbl[0]  = mk_vec(0,0,0,1, dd(32'h8, 32'h4),   mk_exp(1, dd(32'h8, 32'h4),   0,0, 1, dd(32'h8, 32'h4),   0,0,0));
        tbl[1]  = mk_vec(0,0,0,1, dd(32'h10,32'h14),  mk_exp(1, dd(32'h10,32'h14),  0,0, 1, dd(32'h10,32'h14),  0,0,0));
        tbl[2]  = mk_vec(1,0,0,1, dd(32'haa,32'hbb),  mk_exp(1, dd(32'h10,32'h14),  1,0, 1, dd(32'h10,32'h14),  0,1,0));
        tbl[3]  = mk_vec(1,0,0,1, dd(32'hcc,32'hdd),  mk_exp(1, dd(32'h10,32'h14),  2,0, 1, dd(32'h10,32'h14),  0,2,0));
        tbl[4]  = mk_vec(1,0,0,0, dd(32'hee,32'hff),  mk_exp(1, dd(32'h10,32'h14),  3,0, 1, dd(32'h10,32'h14),  0,3,0));
        tbl[5]  = mk_vec(0,1,0,1, dd(32'h1, 32'h2),   mk_exp(0, ZERO,               3,1, 0, NOPS,               0,3,1));
        tbl[6]  = mk_vec(0,0,0,1, dd(32'h20,32'h24),  mk_exp(1, dd(32'h20,32'h24),  3,1, 1, dd(32'h20,32'h24),  0,3,1));
        tbl[7]  = mk_vec(1,1,0,1, dd(32'h30,32'h34),  mk_exp(1, dd(32'h20,32'h24),  4,1, 1, dd(32'h20,32'h24),  1,4,1));
        tbl[8]  = mk_vec(0,0,0,1, dd(32'h40,32'h44),  mk_exp(1, dd(32'h40,32'h44),  4,1, 0, NOPS,               0,4,2));
        tbl[9]  = mk_vec(0,0,0,1, dd(32'h50,32'h54),  mk_exp(1, dd(32'h50,32'h54),  4,1, 1, dd(32'h50,32'h54),  0,4,2));
        tbl[10] = mk_vec(0,0,0,0, dd(32'h60,32'h64),  mk_exp(0, dd(32'h60,32'h64),  4,1, 0, dd(32'h60,32'h64),  0,4,2));
        tbl[11] = mk_vec(1,1,0,1, dd(32'h61,32'h65),  mk_exp(0, dd(32'h60,32'h64),  5,1, 0, dd(32'h60,32'h64),  1,5,2));
        tbl[12] = mk_vec(1,0,0,1, dd(32'h62,32'h66),  mk_exp(0, dd(32'h60,32'h64),  6,1, 0, dd(32'h60,32'h64),  1,6,2));
        tbl[13] = mk_vec(0,1,0,1, dd(32'h70,32'h74),  mk_exp(0, ZERO,               6,2, 0, NOPS,               0,6,3));
        tbl[14] = mk_vec(1,0,1,1, dd(32'h71,32'h75),  mk_exp(0, ZERO,               0,0, 0, NOPS,               0,0,0));
        tbl[15] = mk_vec(0,0,1,1, dd(32'h80,32'h84),  mk_exp(1, dd(32'h80,32'h84),  0,0, 1, dd(32'h80,32'h84),  0,0,0));

        rst_n = 1'b0; bubble = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        in_valid = 1'b0; in_data = '0;
        #12;
        check_all("reset", mk_exp(0, ZERO, 0,0, 0, NOPS, 0,0,0));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), tbl[i].bub, tbl[i].fl, tbl[i].clr,
                 tbl[i].iv, tbl[i].d, tbl[i].e);
        end

        // Random stream: each word must appear one edge later on both instances.
        last_d = '0; last_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d  = {$urandom, $urandom};
            iv = (i % 3) != 0;
            step($sformatf("stream%0d", i), 0, 0, 0, iv, d,
                 mk_exp(iv, d, 0,0, iv, d, 0,0,0));
            last_d = d; last_v = iv;
        end

        // Long stall: 16-bit counter keeps counting, 4-bit one sticks at 15.
        for (int i = 1; i <= 20; i++) begin
            step($sformatf("stall%0d", i), 1, 0, 0, 1, {$urandom, $urandom},
                 mk_exp(last_v, last_d, 16'(i), 0, last_v, last_d, 0,
                        (i > 15) ? 4'd15 : 4'(i), 0));
        end
        step("clr_in_bubble", 1, 0, 1, 1, ZERO,
             mk_exp(last_v, last_d, 0,0, last_v, last_d, 0,0,0));

        // Repeated flushes saturate the narrow flush counter.
        for (int i = 1; i <= 17; i++) begin
            step($sformatf("flush%0d", i), 0, 1, 0, 1, dd(32'hdead, 32'hbeef),
                 mk_exp(0, ZERO, 0, 16'(i), 0, NOPS, 0, 0, (i > 15) ? 4'd15 : 4'(i)));
        end

        // Async reset with data loaded and a flush pending, between edges.
        step("pre_rst_load", 0, 0, 0, 1, dd(32'h90, 32'h94),
             mk_exp(1, dd(32'h90,32'h94), 0,17, 1, dd(32'h90,32'h94), 0,0,15));
        step("pre_rst_arm", 1, 1, 0, 0, dd(32'h91, 32'h95),
             mk_exp(1, dd(32'h90,32'h94), 1,17, 1, dd(32'h90,32'h94), 1,1,15));
        bubble = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", mk_exp(0, ZERO, 0,0, 0, NOPS, 0,0,0));
        #1;
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0, 1, dd(32'ha0, 32'ha4),
             mk_exp(1, dd(32'ha0,32'ha4), 0,0, 1, dd(32'ha0,32'ha4), 0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
